// File: rtl/gfsk_pkg.sv
`default_nettype none
// ============================================================================
// Module : gfsk_pkg
// Brief  : Shared types and symbol-level constants for the GFSK TX sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package gfsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SYNC     = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_TAIL     = 3'd4
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
  localparam logic [15:0] SYM_POS       = 16'h7FFF;
  localparam logic [15:0] SYM_NEG       = 16'h8001;
  localparam logic [15:0] SYM_ZERO      = 16'h0000;

  // NRZ mapping: 1 -> +ampl, 0 -> two's-complement -ampl
  function automatic logic [15:0] nrz_level(input logic b, input logic [15:0] ampl);
    return b ? ampl : (~ampl + 16'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gfsk_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module : gfsk_symbol_timer
// Brief  : Symbol-period wrap counter; emits boundary tick and first-cycle strobe.
// Rev    : 1.0  initial release
// ============================================================================
module gfsk_symbol_timer #(
  parameter int SAMPLES_PER_SYMBOL = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick,
  output logic strobe
);

  localparam int          CW   = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_SYMBOL - 1);

  logic [CW-1:0] count;

  // Held at zero while idle so the first symbol of a frame starts a full period
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick   = enable && (count == LAST);
  assign strobe = enable && (count == '0);

endmodule
`default_nettype wire

// File: rtl/gfsk_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module : gfsk_tx_sequencer
// Brief  : Frame sequencer emitting preamble, sync, payload and tail NRZ symbols.
// Rev    : 1.0  initial release
// ============================================================================
module gfsk_tx_sequencer
  import gfsk_pkg::*;
#(
  parameter int          SAMPLES_PER_SYMBOL = 100,
  parameter int          PREAMBLE_BYTES     = 4,
  parameter logic [31:0] SYNC_WORD          = 32'h8E89BED6,
  parameter int          SYNC_BITS          = 32,
  parameter int          TAIL_SYMBOLS       = 4,
  parameter logic [15:0] SYMBOL_AMPL        = SYM_POS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  payload_len,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [15:0] symbol_out,
  output logic        symbol_strobe,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam logic [15:0] PRE_LAST  = 16'(8 * PREAMBLE_BYTES - 1);
  localparam logic [15:0] SYNC_LAST = 16'(SYNC_BITS - 1);
  localparam logic [15:0] TAIL_LAST = 16'(TAIL_SYMBOLS - 1);
  localparam logic [15:0] BYTE_LAST = 16'd7;

  state_t      state;
  logic [15:0] sym_cnt;
  logic [15:0] sym_next;
  logic [7:0]  len_q;
  logic [7:0]  fetched;
  logic [7:0]  loaded;
  logic [7:0]  hold;
  logic [7:0]  shift;
  logic        hold_full;
  logic        tick;
  logic        xfer;
  logic        need_load;
  logic        do_load;
  logic        starve;

  gfsk_symbol_timer #(
    .SAMPLES_PER_SYMBOL(SAMPLES_PER_SYMBOL)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (busy),
    .tick   (tick),
    .strobe (symbol_strobe)
  );

  assign busy     = (state != ST_IDLE);
  assign tx_ready = ((state == ST_SYNC) || (state == ST_PAYLOAD)) && !hold_full
                    && (fetched < len_q);
  assign xfer     = tx_valid && tx_ready;
  assign sym_next = sym_cnt + 16'd1;

  // A byte is needed at the end of the sync word or at the end of a payload byte
  // whenever more payload remains to be sent.
  always_comb begin
    need_load = 1'b0;
    if (tick) begin
      if (state == ST_SYNC && sym_cnt == SYNC_LAST) begin
        need_load = (len_q != 8'd0);
      end else if (state == ST_PAYLOAD && sym_cnt == BYTE_LAST) begin
        need_load = (loaded < len_q);
      end
    end
  end

  assign do_load = need_load && hold_full;
  assign starve  = need_load && !hold_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sym_cnt    <= '0;
      len_q      <= '0;
      fetched    <= '0;
      loaded     <= '0;
      hold       <= '0;
      shift      <= '0;
      hold_full  <= 1'b0;
      symbol_out <= SYM_ZERO;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_PREAMBLE;
            len_q      <= payload_len;
            sym_cnt    <= '0;
            fetched    <= '0;
            loaded     <= '0;
            hold_full  <= 1'b0;
            symbol_out <= nrz_level(PREAMBLE_BYTE[0], SYMBOL_AMPL);
          end
        end
        ST_PREAMBLE: begin
          if (tick) begin
            if (sym_cnt == PRE_LAST) begin
              state      <= ST_SYNC;
              sym_cnt    <= '0;
              symbol_out <= nrz_level(SYNC_WORD[0], SYMBOL_AMPL);
            end else begin
              sym_cnt    <= sym_next;
              symbol_out <= nrz_level(PREAMBLE_BYTE[sym_next[2:0]], SYMBOL_AMPL);
            end
          end
        end
        ST_SYNC: begin
          if (tick) begin
            if (sym_cnt != SYNC_LAST) begin
              sym_cnt    <= sym_next;
              symbol_out <= nrz_level(SYNC_WORD[sym_next[4:0]], SYMBOL_AMPL);
            end else begin
              state      <= do_load ? ST_PAYLOAD : ST_TAIL;
              sym_cnt    <= '0;
              symbol_out <= do_load ? nrz_level(hold[0], SYMBOL_AMPL) : SYM_ZERO;
            end
          end
        end
        ST_PAYLOAD: begin
          if (tick) begin
            if (sym_cnt != BYTE_LAST) begin
              sym_cnt    <= sym_next;
              shift      <= shift >> 1;
              symbol_out <= nrz_level(shift[1], SYMBOL_AMPL);
            end else begin
              state      <= do_load ? ST_PAYLOAD : ST_TAIL;
              sym_cnt    <= '0;
              symbol_out <= do_load ? nrz_level(hold[0], SYMBOL_AMPL) : SYM_ZERO;
            end
          end
        end
        ST_TAIL: begin
          if (tick) begin
            symbol_out <= SYM_ZERO;
            if (sym_cnt == TAIL_LAST) begin
              state   <= ST_IDLE;
              sym_cnt <= '0;
              done    <= 1'b1;
            end else begin
              sym_cnt <= sym_next;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (do_load) begin
        shift     <= hold;
        hold_full <= 1'b0;
        loaded    <= loaded + 8'd1;
      end
      if (starve) begin
        underrun <= 1'b1;
      end
      // A new byte may land in the same edge the old one moves to the shifter
      if (xfer) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
        fetched   <= fetched + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gfsk_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_gfsk_tx_sequencer
// Brief  : Self-checking bench for gfsk_tx_sequencer against a frame-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gfsk_tx_sequencer;

  localparam int          SPS  = 4;
  localparam int          PB   = 1;
  localparam int          SB   = 8;
  localparam int          TAIL = 2;
  localparam logic [31:0] SW   = 32'h8E89BED6;
  localparam int          WAIT_BUDGET = 20000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  payload_len;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] symbol_out;
  logic        symbol_strobe;
  logic        busy;
  logic        done;
  logic        underrun;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] pay [256];

  always #5 clk = ~clk;

  gfsk_tx_sequencer #(
    .SAMPLES_PER_SYMBOL(SPS),
    .PREAMBLE_BYTES    (PB),
    .SYNC_WORD         (SW),
    .SYNC_BITS         (SB),
    .TAIL_SYMBOLS      (TAIL),
    .SYMBOL_AMPL       (16'h7FFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .payload_len  (payload_len),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .symbol_out   (symbol_out),
    .symbol_strobe(symbol_strobe),
    .busy         (busy),
    .done         (done),
    .underrun     (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] lvl(input logic b);
    return b ? 16'h7FFF : 16'h8001;
  endfunction

  task automatic produce(input int count, input int max_gap);
    for (int i = 0; i < count; i++) begin
      int gap;
      int waited;
      gap    = int'($urandom_range(max_gap, 0));
      waited = 0;
      repeat (gap) @(negedge clk);
      tx_data  = pay[i];
      tx_valid = 1'b1;
      while (!tx_ready && waited < WAIT_BUDGET) begin
        @(negedge clk);
        waited++;
      end
      if (!tx_ready) begin
        check("tx_ready_wait", 32'd0, 32'd1);
        tx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1 tx_valid = 1'b0;
    end
  endtask

  // Called just after the edge that sampled start; ends at the done cycle.
  task automatic check_frame(input int len, input int supply, input int max_gap);
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int sent;
    int ur_cycle;
    int nsym;
    sent     = (supply < len) ? supply : len;
    ur_cycle = (supply < len) ? (8 * PB + SB + 8 * sent) * SPS + 1 : -1;
    for (int i = 0; i < 8 * PB; i++) exp_q.push_back(lvl(((32'hAA >> (i % 8)) & 32'd1) != 0));
    for (int i = 0; i < SB; i++)     exp_q.push_back(lvl(((SW >> i) & 32'd1) != 0));
    for (int b = 0; b < sent; b++)
      for (int j = 0; j < 8; j++)    exp_q.push_back(lvl(((pay[b] >> j) & 8'd1) != 0));
    for (int i = 0; i < TAIL; i++)   exp_q.push_back(16'h0000);
    nsym = exp_q.size();

    fork
      produce(sent, max_gap);
      begin
        for (int c = 1; c <= nsym * SPS; c++) begin
          int idx;
          @(negedge clk);
          idx = (c - 1) / SPS;
          check("symbol_out", 32'(symbol_out), 32'(exp_q[idx]));
          check("symbol_strobe", 32'(symbol_strobe), 32'((c - 1) % SPS == 0));
          check("busy", 32'(busy), 32'd1);
          check("done_early", 32'(done), 32'd0);
          check("underrun", 32'(underrun), 32'(c == ur_cycle));
          if (len == 0 || idx < 8 * PB || idx >= nsym - TAIL)
            check("tx_ready_off", 32'(tx_ready), 32'd0);
          if (symbol_strobe) got_q.push_back(symbol_out);
        end
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("symbol_at_done", 32'(symbol_out), 32'd0);
        check("strobe_at_done", 32'(symbol_strobe), 32'd0);
        check("underrun_at_done", 32'(underrun), 32'd0);
      end
    join

    check("strobe_count", 32'(got_q.size()), 32'(nsym));
    for (int b = 0; b < sent; b++) begin
      logic [7:0] rec;
      rec = 8'd0;
      for (int j = 0; j < 8; j++) begin
        int k;
        k = 8 * PB + SB + 8 * b + j;
        if (k < got_q.size() && got_q[k] == 16'h7FFF) rec = rec | (8'd1 << j);
      end
      check("payload_byte", 32'(rec), 32'(pay[b]));
    end
  endtask

  task automatic begin_frame(input int len);
    @(negedge clk);
    start       = 1'b1;
    payload_len = 8'(len);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    payload_len = 8'd0;
    tx_data     = 8'd0;
    tx_valid    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_symbol", 32'(symbol_out), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_strobe", 32'(symbol_strobe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;

    // Single byte 0x01 offered immediately
    pay[0] = 8'h01;
    begin_frame(1);
    check_frame(1, 1, 0);

    // Empty payload
    begin_frame(0);
    check_frame(0, 0, 0);

    // Second byte withheld
    for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
    begin_frame(2);
    check_frame(2, 1, 3);
    repeat (3) begin
      @(negedge clk);
      check("busy_after_underrun", 32'(busy), 32'd0);
    end

    // Reset in the middle of the payload
    @(negedge clk);
    start       = 1'b1;
    payload_len = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    repeat (70) @(negedge clk);
    check("busy_mid_payload", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_symbol", 32'(symbol_out), 32'd0);
    check("abort_ready", 32'(tx_ready), 32'd0);
    check("abort_strobe", 32'(symbol_strobe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_underrun", 32'(underrun), 32'd0);
    reset    = 1'b0;
    tx_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 32'd0);
      check("idle_after_abort", 32'(busy), 32'd0);
    end
    begin_frame(3);
    check_frame(3, 3, 10);

    // start held through the frame and into the done cycle
    @(negedge clk);
    start       = 1'b1;
    payload_len = 8'd0;
    @(posedge clk);
    #1;
    check_frame(0, 0, 0);
    @(posedge clk);
    #1 start = 1'b0;
    check_frame(0, 0, 0);

    // Randomised short frames, some starved
    for (int f = 0; f < 4; f++) begin
      int len;
      int sup;
      for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
      len = int'($urandom_range(6, 0));
      sup = ($urandom_range(2, 0) == 0 && len > 0) ? int'($urandom_range(len - 1, 0)) : len;
      begin_frame(len);
      check_frame(len, sup, 20);
    end

    // Maximum length with gaps inside one byte time
    for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
    begin_frame(255);
    check_frame(255, 255, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
